oled_cmd_rx: RTL and testbench
==============================

OLED_CMD_RX -- requirements
Module: oled_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of clk cycles with sclk idle high after which a partial byte is discarded.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port sclk, input, 1: SPI clock from the master; idles high; asynchronous to clk.
REQ-005 SHALL have port sdo, input, 1: SPI data from the master, sent MSB first.
REQ-006 SHALL have port dc, input, 1: 0 = command byte, 1 = data byte.
REQ-007 SHALL have port res, input, 1: display reset, active low.
REQ-008 SHALL have port vdd, input, 1: logic supply enable, active low; reception is ignored while vdd=1.
REQ-009 SHALL have port byte_valid, output, 1: one-cycle strobe marking a received byte.
REQ-010 SHALL have ports byte_data (output, 8) and byte_dc (output, 1): the received byte and the dc value sampled with it.
REQ-011 SHALL have ports disp_on, entire_on, seg_remap, com_remap and charge_pump, each output, 1: decoded panel state.
REQ-012 SHALL have ports contrast (output, 8), precharge (output, 8), com_cfg (output, 8) and mem_mode (output, 2): decoded panel settings.
REQ-013 SHALL have port cmd_err, output, 1: one-cycle strobe marking a protocol error.

Function
REQ-014 sclk, sdo, dc, res and vdd SHALL each pass through a 2-flop synchronizer of equal depth.
REQ-015 A synchronized sclk rising edge SHALL shift the synchronized sdo into an 8-bit shift register, MSB first, and increment a 3-bit bit counter.
REQ-016 sclk high time and low time SHALL each be at least 3 clk cycles; behaviour at faster sclk is undefined.
REQ-017 The cycle after the 8th edge is detected, byte_valid SHALL be 1 for exactly one cycle, with byte_data and byte_dc held until the next byte.
REQ-018 The bit counter SHALL wrap to 0 after the 8th bit, so back-to-back bytes need no gap.
REQ-019 When sclk stays high for TIMEOUT consecutive cycles with the bit counter nonzero, the bit counter SHALL clear and the partial byte SHALL be dropped with no strobe.
REQ-020 While vdd=1 or res=0 (synchronized), edges SHALL be ignored and the bit counter held at 0.
REQ-021 The decoder FSM SHALL have two states, IDLE and ARG; in ARG it holds the pending opcode.
REQ-022 In IDLE, a command byte SHALL update state as follows, with no state change:
- AE/AF: disp_on = 0/1
- A4/A5: entire_on = 0/1
- A0/A1: seg_remap = 0/1
- C0/C8: com_remap = 0/1
REQ-023 In IDLE, command opcodes 81, 8D, D9, DA and 20 SHALL store the opcode and move to ARG.
REQ-024 In IDLE, any other command byte SHALL strobe byte_valid only; data bytes (dc=1) are passed through with no decode.
REQ-025 In ARG, a command byte SHALL be the argument and return the FSM to IDLE:
- 81: contrast = arg
- 8D: charge_pump = arg[2]
- D9: precharge = arg
- DA: com_cfg = arg
- 20: mem_mode = arg[1:0]
REQ-026 In ARG, a data byte SHALL pulse cmd_err for one cycle (same cycle as byte_valid), leave settings unchanged and return to IDLE.
REQ-027 Decoded outputs SHALL update in the same cycle byte_valid is asserted.

Reset
REQ-028 On rst_n=0 at a clk edge, the following SHALL hold:
- FSM = IDLE, bit counter = 0, synchronizers = idle (sclk=1, res=1, vdd=1)
- byte_valid = 0, cmd_err = 0, byte_data = 0x00, byte_dc = 0
- disp_on = 0, entire_on = 0, seg_remap = 0, com_remap = 0, charge_pump = 0
- contrast = 0x7F, precharge = 0x22, com_cfg = 0x12, mem_mode = 2'b10
REQ-029 Synchronized res=0 SHALL restore every decoded setting and the FSM to the reset values, including mid-byte and mid-argument; byte_data and byte_dc are retained.

Configuration
REQ-030 With macro OLED_RX_CNT_EN defined, the block SHALL add output byte_cnt (16 bits, reset 0); it increments on each byte_valid, wraps 0xFFFF to 0, and clears on res=0.
REQ-031 Without OLED_RX_CNT_EN, byte_cnt and its counter SHALL not exist.

Structure
REQ-032 Package oled_pkg SHALL hold:
- the opcode constants
- the rx_state_e enum (IDLE, ARG)
- the reset-default constants for contrast, precharge, com_cfg and mem_mode
REQ-033 Sub-module spi_rx_shift SHALL contain the synchronizers, edge detect, timeout counter and shift register, and deliver the byte, dc and a strobe to the decoder.

Verification
REQ-034 Release rst_n -> contrast=0x7F, precharge=0x22, com_cfg=0x12, mem_mode=2'b10, disp_on=0.
REQ-035 Send AF with dc=0 -> one byte_valid with byte_data=0xAF, byte_dc=0; disp_on=1 in the same cycle.
REQ-036 Send 81 then 0F back-to-back -> contrast stays 0x7F after the first byte and becomes 0x0F after the second; two strobes.
REQ-037 Send 8D then 55 with dc=1 -> cmd_err pulses with the second byte_valid; charge_pump=0; FSM=IDLE; a following 8D,14 sets charge_pump=1.
REQ-038 Send 5 bits, idle sclk high 70 cycles, then A1 -> exactly one strobe, byte_data=0xA1, seg_remap=1.
REQ-039 Set contrast to 0x0F, send 20, then pull res low -> all settings back at reset values and FSM=IDLE; with OLED_RX_CNT_EN, byte_cnt=0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED command receiver: decoder states,
// controller opcodes and power-on defaults of the decoded panel settings.
package oled_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } rx_state_e;

    // Single-byte commands
    localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISP_ON     = 8'hAF;
    localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
    localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
    localparam logic [7:0] OP_SEG_NORM    = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] OP_COM_NORM    = 8'hC0;
    localparam logic [7:0] OP_COM_REMAP   = 8'hC8;

    // Commands followed by one argument byte
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_COM_CFG     = 8'hDA;
    localparam logic [7:0] OP_MEM_MODE    = 8'h20;

    // Power-on defaults of the decoded settings
    localparam logic [7:0] CONTRAST_RST   = 8'h7F;
    localparam logic [7:0] PRECHARGE_RST  = 8'h22;
    localparam logic [7:0] COM_CFG_RST    = 8'h12;
    localparam logic [1:0] MEM_MODE_RST   = 2'b10;

    // True for opcodes that expect an argument byte next
    function automatic logic is_arg_opcode(input logic [7:0] op);
        return (op == OP_CONTRAST)  || (op == OP_CHARGE_PUMP) ||
               (op == OP_PRECHARGE) || (op == OP_COM_CFG)     ||
               (op == OP_MEM_MODE);
    endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// SPI byte receiver front end: synchronizes the master's pins into the clk
// domain, detects sclk rising edges, shifts sdo MSB first and discards a
// partial byte when sclk idles high for TIMEOUT cycles. Reception is held off
// while vdd is high or res is low.
module spi_rx_shift
    import oled_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sdo,
    input  logic       dc,
    input  logic       res,
    input  logic       vdd,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       res_sync
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    sclk_sync;
    logic [1:0]    sdo_sync;
    logic [1:0]    dc_sync;
    logic [1:0]    res_sync_q;
    logic [1:0]    vdd_sync;
    logic          sclk_q;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] to_cnt;

    logic sclk_s;
    logic rx_en;
    logic sclk_rise;

    assign sclk_s    = sclk_sync[1];
    assign rx_en     = ~vdd_sync[1] & res_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign res_sync  = res_sync_q[1];

    // The completed byte is presented combinationally on the 8th edge so the
    // decoder can register byte, strobe and settings on the same clk edge.
    assign rx_strobe = rx_en & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg[6:0], sdo_sync[1]};
    assign rx_dc     = dc_sync[1];

    // Two-flop synchronizers, reset to the idle pin levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync  <= '1;
            sdo_sync   <= '0;
            dc_sync    <= '0;
            res_sync_q <= '1;
            vdd_sync   <= '1;
            sclk_q     <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            sdo_sync   <= {sdo_sync[0], sdo};
            dc_sync    <= {dc_sync[0], dc};
            res_sync_q <= {res_sync_q[0], res};
            vdd_sync   <= {vdd_sync[0], vdd};
            sclk_q     <= sclk_s;
        end
    end

    // Shift register, bit counter and idle-high timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (!rx_en) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (sclk_rise) begin
            shreg   <= {shreg[6:0], sdo_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
            to_cnt  <= '0;
        end else if (sclk_s && (bit_cnt != 3'd0)) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end else begin
            to_cnt <= '0;
        end
    end

endmodule

// File: rtl/oled_cmd_rx.sv
// OLED controller command receiver: receives SPI bytes and decodes the
// command stream into panel state and settings. Two-byte commands park the
// opcode in the ARG state until their argument arrives.
// Optional feature: define OLED_RX_CNT_EN to add the 16-bit byte_cnt output.
module oled_cmd_rx
    import oled_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sdo,
    input  logic        dc,
    input  logic        res,
    input  logic        vdd,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        disp_on,
    output logic        entire_on,
    output logic        seg_remap,
    output logic        com_remap,
    output logic        charge_pump,
    output logic [7:0]  contrast,
    output logic [7:0]  precharge,
    output logic [7:0]  com_cfg,
    output logic [1:0]  mem_mode,
    output logic        cmd_err
`ifdef OLED_RX_CNT_EN
    ,
    output logic [15:0] byte_cnt
`endif
);

    logic       rx_strobe;
    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       res_sync;

    rx_state_e  state;
    logic [7:0] pend_op;

    spi_rx_shift #(
        .TIMEOUT (TIMEOUT)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .sdo       (sdo),
        .dc        (dc),
        .res       (res),
        .vdd       (vdd),
        .rx_strobe (rx_strobe),
        .rx_byte   (rx_byte),
        .rx_dc     (rx_dc),
        .res_sync  (res_sync)
    );

    // Decoder FSM: registers the byte, strobes and all decoded settings
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend_op     <= '0;
            byte_valid  <= 1'b0;
            cmd_err     <= 1'b0;
            byte_data   <= '0;
            byte_dc     <= 1'b0;
            disp_on     <= 1'b0;
            entire_on   <= 1'b0;
            seg_remap   <= 1'b0;
            com_remap   <= 1'b0;
            charge_pump <= 1'b0;
            contrast    <= CONTRAST_RST;
            precharge   <= PRECHARGE_RST;
            com_cfg     <= COM_CFG_RST;
            mem_mode    <= MEM_MODE_RST;
        end else begin
            byte_valid <= 1'b0;
            cmd_err    <= 1'b0;
            if (!res_sync) begin
                // Display reset restores settings but keeps the last byte
                state       <= IDLE;
                pend_op     <= '0;
                disp_on     <= 1'b0;
                entire_on   <= 1'b0;
                seg_remap   <= 1'b0;
                com_remap   <= 1'b0;
                charge_pump <= 1'b0;
                contrast    <= CONTRAST_RST;
                precharge   <= PRECHARGE_RST;
                com_cfg     <= COM_CFG_RST;
                mem_mode    <= MEM_MODE_RST;
            end else if (rx_strobe) begin
                byte_valid <= 1'b1;
                byte_data  <= rx_byte;
                byte_dc    <= rx_dc;
                case (state)
                    IDLE: begin
                        if (!rx_dc) begin
                            if (is_arg_opcode(rx_byte)) begin
                                pend_op <= rx_byte;
                                state   <= ARG;
                            end else begin
                                case (rx_byte)
                                    OP_DISP_OFF:   disp_on   <= 1'b0;
                                    OP_DISP_ON:    disp_on   <= 1'b1;
                                    OP_ENTIRE_OFF: entire_on <= 1'b0;
                                    OP_ENTIRE_ON:  entire_on <= 1'b1;
                                    OP_SEG_NORM:   seg_remap <= 1'b0;
                                    OP_SEG_REMAP:  seg_remap <= 1'b1;
                                    OP_COM_NORM:   com_remap <= 1'b0;
                                    OP_COM_REMAP:  com_remap <= 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    ARG: begin
                        state <= IDLE;
                        if (rx_dc) begin
                            cmd_err <= 1'b1;
                        end else begin
                            case (pend_op)
                                OP_CONTRAST:    contrast    <= rx_byte;
                                OP_CHARGE_PUMP: charge_pump <= rx_byte[2];
                                OP_PRECHARGE:   precharge   <= rx_byte;
                                OP_COM_CFG:     com_cfg     <= rx_byte;
                                OP_MEM_MODE:    mem_mode    <= rx_byte[1:0];
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef OLED_RX_CNT_EN
    // Received-byte counter, visible in the same cycle as the strobe
    always_ff @(posedge clk) begin
        if (!rst_n || !res_sync) begin
            byte_cnt <= '0;
        end else if (rx_strobe) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oled_cmd_rx.sv
// Scoreboard bench for oled_cmd_rx: stimulus pushes the hand-computed
// response of each byte; a monitor pops and compares on every byte_valid.
`timescale 1ns/1ps
module tb_oled_cmd_rx;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       err;
        logic       disp_on;
        logic       entire_on;
        logic       seg_remap;
        logic       com_remap;
        logic       charge_pump;
        logic [7:0] contrast;
        logic [7:0] precharge;
        logic [7:0] com_cfg;
        logic [1:0] mem_mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, sclk, sdo, dc, res, vdd;
    logic        byte_valid, byte_dc, cmd_err;
    logic [7:0]  byte_data, contrast, precharge, com_cfg;
    logic        disp_on, entire_on, seg_remap, com_remap, charge_pump;
    logic [1:0]  mem_mode;
`ifdef OLED_RX_CNT_EN
    logic [15:0] byte_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    exp_t rst_vals;
    exp_t mon_e;

    always #5 clk = ~clk;

    oled_cmd_rx #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .sdo         (sdo),
        .dc          (dc),
        .res         (res),
        .vdd         (vdd),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_dc     (byte_dc),
        .disp_on     (disp_on),
        .entire_on   (entire_on),
        .seg_remap   (seg_remap),
        .com_remap   (com_remap),
        .charge_pump (charge_pump),
        .contrast    (contrast),
        .precharge   (precharge),
        .com_cfg     (com_cfg),
        .mem_mode    (mem_mode),
        .cmd_err     (cmd_err)
`ifdef OLED_RX_CNT_EN
        ,
        .byte_cnt    (byte_cnt)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [7:0] b, input logic d, input int n);
        dc = d;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            sdo  = b[7-i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input logic err);
        exp_t e;
        e      = cur;
        e.data = b;
        e.dc   = d;
        e.err  = err;
        exp_q.push_back(e);
        shift_bits(b, d, 8);
    endtask

    task automatic chk_settings(input string tag, input exp_t e);
        chk({tag, "_disp_on"},     {15'd0, disp_on},     {15'd0, e.disp_on});
        chk({tag, "_entire_on"},   {15'd0, entire_on},   {15'd0, e.entire_on});
        chk({tag, "_seg_remap"},   {15'd0, seg_remap},   {15'd0, e.seg_remap});
        chk({tag, "_com_remap"},   {15'd0, com_remap},   {15'd0, e.com_remap});
        chk({tag, "_charge_pump"}, {15'd0, charge_pump}, {15'd0, e.charge_pump});
        chk({tag, "_contrast"},    {8'd0, contrast},     {8'd0, e.contrast});
        chk({tag, "_precharge"},   {8'd0, precharge},    {8'd0, e.precharge});
        chk({tag, "_com_cfg"},     {8'd0, com_cfg},      {8'd0, e.com_cfg});
        chk({tag, "_mem_mode"},    {14'd0, mem_mode},    {14'd0, e.mem_mode});
    endtask

    // Monitor: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (byte_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got byte %h, expected no strobe", byte_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("byte_data", {8'd0, byte_data}, {8'd0, mon_e.data});
                    chk("byte_dc",   {15'd0, byte_dc},  {15'd0, mon_e.dc});
                    chk("cmd_err",   {15'd0, cmd_err},  {15'd0, mon_e.err});
                    chk_settings("strobe", mon_e);
                end
            end else if (cmd_err !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stray_cmd_err: got %b, expected 0 without byte_valid", cmd_err);
            end
        end
    end

    initial begin
        rst_vals = '{data: 8'h00, dc: 1'b0, err: 1'b0, disp_on: 1'b0, entire_on: 1'b0,
                     seg_remap: 1'b0, com_remap: 1'b0, charge_pump: 1'b0,
                     contrast: 8'h7F, precharge: 8'h22, com_cfg: 8'h12, mem_mode: 2'b10};
        cur   = rst_vals;
        rst_n = 1'b0;
        sclk  = 1'b1;
        sdo   = 1'b0;
        dc    = 1'b0;
        res   = 1'b1;
        vdd   = 1'b0;
        wait_clks(5);

        // Reset state, held and after release
        chk("rst_byte_valid", {15'd0, byte_valid}, 16'd0);
        chk("rst_cmd_err",    {15'd0, cmd_err},    16'd0);
        chk("rst_byte_data",  {8'd0, byte_data},   16'd0);
        chk("rst_byte_dc",    {15'd0, byte_dc},    16'd0);
        rst_n = 1'b1;
        wait_clks(5);
        chk_settings("rst", rst_vals);
`ifdef OLED_RX_CNT_EN
        chk("rst_byte_cnt", byte_cnt, 16'd0);
`endif

        // Display on
        cur.disp_on = 1'b1;
        send_byte(8'hAF, 1'b0, 1'b0);

        // Contrast: opcode leaves it untouched, argument sets it
        send_byte(8'h81, 1'b0, 1'b0);
        cur.contrast = 8'h0F;
        send_byte(8'h0F, 1'b0, 1'b0);

        // Data byte in place of an argument is an error and returns to IDLE
        send_byte(8'h8D, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'h8D, 1'b0, 1'b0);
        cur.charge_pump = 1'b1;
        send_byte(8'h14, 1'b0, 1'b0);

        // Partial byte discarded after sclk idles high beyond the timeout
        shift_bits(8'hF8, 1'b0, 5);
        wait_clks(70);
        cur.seg_remap = 1'b1;
        send_byte(8'hA1, 1'b0, 1'b0);

        // Remaining single-byte and argument commands, pass-through, unknown
        cur.entire_on = 1'b1;
        send_byte(8'hA5, 1'b0, 1'b0);
        cur.com_remap = 1'b1;
        send_byte(8'hC8, 1'b0, 1'b0);
        send_byte(8'hD9, 1'b0, 1'b0);
        cur.precharge = 8'hF1;
        send_byte(8'hF1, 1'b0, 1'b0);
        send_byte(8'hDA, 1'b0, 1'b0);
        cur.com_cfg = 8'h02;
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        cur.mem_mode = 2'b01;
        send_byte(8'hFD, 1'b0, 1'b0);
        send_byte(8'hAE, 1'b1, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b0);
        cur.disp_on = 1'b0;
        send_byte(8'hAE, 1'b0, 1'b0);
        cur.disp_on = 1'b1;
        send_byte(8'hAF, 1'b0, 1'b0);
        cur.entire_on = 1'b0;
        send_byte(8'hA4, 1'b0, 1'b0);
        wait_clks(10);

        // vdd high: a full byte is ignored
        vdd = 1'b1;
        wait_clks(4);
        shift_bits(8'hAE, 1'b0, 8);
        wait_clks(6);
        vdd = 1'b0;
        wait_clks(4);
        chk("vdd_ignored_disp_on", {15'd0, disp_on}, 16'd1);
        chk("vdd_ignored_data",    {8'd0, byte_data}, 16'h00A4);

        // res low mid-argument restores settings, keeps the last byte
        send_byte(8'h20, 1'b0, 1'b0);
        wait_clks(10);
        res = 1'b0;
        wait_clks(4);
        chk_settings("res", rst_vals);
        chk("res_byte_data", {8'd0, byte_data}, 16'h0020);
        chk("res_byte_dc",   {15'd0, byte_dc},  16'd0);
`ifdef OLED_RX_CNT_EN
        chk("res_byte_cnt", byte_cnt, 16'd0);
`endif
        res = 1'b1;
        wait_clks(4);
        // AF decodes as a command only if the FSM went back to IDLE
        cur = rst_vals;
        cur.disp_on = 1'b1;
        send_byte(8'hAF, 1'b0, 1'b0);
`ifdef OLED_RX_CNT_EN
        wait_clks(10);
        chk("cnt_after_res", byte_cnt, 16'd1);
`endif

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clks(1);
        wait_clks(5);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
